// File: rtl/slot_pkg.sv
// Shared types and constants for the slot-machine reel controller.
`timescale 1ns/1ps
package slot_pkg;

    localparam int unsigned DIGIT_W   = 4;
    localparam int unsigned NUM_REELS = 3;
    localparam int unsigned NUM_BTNS  = NUM_REELS + 1;

    // Per-reel advance amounts; coprime with 10 so every reel visits all symbols.
    localparam logic [DIGIT_W-1:0] REEL_STEP0 = 4'd1;
    localparam logic [DIGIT_W-1:0] REEL_STEP1 = 4'd3;
    localparam logic [DIGIT_W-1:0] REEL_STEP2 = 4'd7;

    localparam logic [DIGIT_W-1:0] JACKPOT_DIGIT = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SPIN   = 2'd1,
        ST_RESULT = 2'd2
    } state_e;

    // BCD add modulo 10; operands are always 0..9.
    function automatic logic [DIGIT_W-1:0] next_digit(input logic [DIGIT_W-1:0] d,
                                                      input logic [DIGIT_W-1:0] step);
        logic [DIGIT_W:0] sum;
        sum = {1'b0, d} + {1'b0, step};
        if (sum >= 5'd10) begin
            sum = sum - 5'd10;
        end
        return sum[DIGIT_W-1:0];
    endfunction

endpackage

// File: rtl/reel_counter.sv
// One reel: BCD symbol register stepped modulo 10 unless frozen.
`timescale 1ns/1ps
module reel_counter
    import slot_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DIGIT_W-1:0] step,
    input  logic               advance,
    input  logic               freeze,
    output logic [DIGIT_W-1:0] digit
);

    logic [DIGIT_W-1:0] digit_q;
    logic [DIGIT_W-1:0] digit_d;

    // Next symbol: freeze wins over a coincident advance.
    always_comb begin
        digit_d = digit_q;
        if (advance && !freeze) begin
            digit_d = next_digit(digit_q, step);
        end
    end

    // Symbol register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;

endmodule

// File: rtl/slot_reel_ctrl.sv
// Three-reel slot machine controller: button conditioning, spin FSM, result flags.
`timescale 1ns/1ps
module slot_reel_ctrl
    import slot_pkg::*;
#(
    parameter int unsigned TIMEOUT_TICKS = 100
) (
    input  logic       clock6MHz,
    input  logic       resetN,
    input  logic       tick10Hz,
    input  logic       startBtn,
    input  logic [2:0] stopBtn,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [2:0] stopped,
    output logic       busy,
    output logic       win,
    output logic       pair,
    output logic       jackpot
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_TICKS + 1);

    // Button conditioning: bit 0 = start, bits 3:1 = stop reel 0..2.
    logic [NUM_BTNS-1:0] sync1_q, sync1_d;
    logic [NUM_BTNS-1:0] sync2_q, sync2_d;
    logic [NUM_BTNS-1:0] prev_q,  prev_d;
    logic [1:0]          settle_q, settle_d;
    logic [NUM_BTNS-1:0] btn_ev;
    logic                start_ev;
    logic [2:0]          stop_ev;

    state_e              state_q, state_d;
    logic [2:0]          stopped_q, stopped_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                win_q, win_d;
    logic                pair_q, pair_d;
    logic                jackpot_q, jackpot_d;

    logic                in_spin;
    logic                timeout_hit;
    logic [2:0]          stop_acc;
    logic [2:0]          freeze_vec;
    logic                reel_adv;
    logic [DIGIT_W-1:0]  d0, d1, d2;

    // Two-flop synchroniser and rising-edge detect; events masked until the
    // pipeline holds real samples so a button held through reset stays silent.
    always_comb begin
        sync1_d  = {stopBtn, startBtn};
        sync2_d  = sync1_q;
        prev_d   = sync2_q;
        settle_d = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
        btn_ev   = sync2_q & ~prev_q & {NUM_BTNS{settle_q == 2'd3}};
        start_ev = btn_ev[0];
        stop_ev  = btn_ev[3:1];
    end

    // All sequential state.
    always_ff @(posedge clock6MHz or negedge resetN) begin
        if (!resetN) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            settle_q  <= '0;
            state_q   <= ST_IDLE;
            stopped_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            win_q     <= 1'b0;
            pair_q    <= 1'b0;
            jackpot_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            settle_q  <= settle_d;
            state_q   <= state_d;
            stopped_q <= stopped_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            win_q     <= win_d;
            pair_q    <= pair_d;
            jackpot_q <= jackpot_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_ev) state_d = ST_SPIN;
            ST_SPIN:   if (stopped_q == 3'b111) state_d = ST_RESULT;
            ST_RESULT: if (start_ev) state_d = ST_SPIN;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Reel freeze control, timeout counter and result flags.
    always_comb begin
        in_spin     = (state_q == ST_SPIN);
        stop_acc    = in_spin ? (stop_ev & ~stopped_q) : 3'b000;
        timeout_hit = in_spin && (cnt_q == CNT_W'(TIMEOUT_TICKS));
        freeze_vec  = stopped_q | stop_acc | {3{timeout_hit}};
        reel_adv    = in_spin && tick10Hz;

        stopped_d = stopped_q;
        cnt_d     = cnt_q;
        if (!in_spin && state_d == ST_SPIN) begin
            stopped_d = 3'b000;
            cnt_d     = '0;
        end else if (in_spin) begin
            stopped_d = freeze_vec;
            if (stop_acc != 3'b000) begin
                cnt_d = '0;
            end else if (tick10Hz && cnt_q < CNT_W'(TIMEOUT_TICKS)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        busy_d    = (state_d == ST_SPIN);
        win_d     = win_q;
        pair_d    = pair_q;
        jackpot_d = jackpot_q;
        if (state_d != ST_RESULT) begin
            win_d     = 1'b0;
            pair_d    = 1'b0;
            jackpot_d = 1'b0;
        end else if (in_spin) begin
            // Digits are stable once every reel is frozen; latch on entry.
            win_d     = (d0 == d1) && (d1 == d2);
            jackpot_d = win_d && (d0 == JACKPOT_DIGIT);
            pair_d    = ((d0 == d1) || (d1 == d2) || (d0 == d2)) && !win_d;
        end
    end

    reel_counter u_reel0 (
        .clk     (clock6MHz),
        .rst_n   (resetN),
        .step    (REEL_STEP0),
        .advance (reel_adv),
        .freeze  (freeze_vec[0]),
        .digit   (d0)
    );

    reel_counter u_reel1 (
        .clk     (clock6MHz),
        .rst_n   (resetN),
        .step    (REEL_STEP1),
        .advance (reel_adv),
        .freeze  (freeze_vec[1]),
        .digit   (d1)
    );

    reel_counter u_reel2 (
        .clk     (clock6MHz),
        .rst_n   (resetN),
        .step    (REEL_STEP2),
        .advance (reel_adv),
        .freeze  (freeze_vec[2]),
        .digit   (d2)
    );

    assign digit0  = d0;
    assign digit1  = d1;
    assign digit2  = d2;
    assign stopped = stopped_q;
    assign busy    = busy_q;
    assign win     = win_q;
    assign pair    = pair_q;
    assign jackpot = jackpot_q;

endmodule

// File: tb/tb_slot_reel_ctrl.sv
// Directed bench for slot_reel_ctrl; expected values worked out by hand.
`timescale 1ns/1ps
module tb_slot_reel_ctrl;

    logic       clk = 1'b0;
    logic       resetN;
    logic       tick10Hz;
    logic       startBtn;
    logic [2:0] stopBtn;
    logic [3:0] digit0, digit1, digit2;
    logic [2:0] stopped;
    logic       busy, win, pair, jackpot;

    int checks = 0;
    int errors = 0;

    slot_reel_ctrl #(.TIMEOUT_TICKS(100)) dut (
        .clock6MHz (clk),
        .resetN    (resetN),
        .tick10Hz  (tick10Hz),
        .startBtn  (startBtn),
        .stopBtn   (stopBtn),
        .digit0    (digit0),
        .digit1    (digit1),
        .digit2    (digit2),
        .stopped   (stopped),
        .busy      (busy),
        .win       (win),
        .pair      (pair),
        .jackpot   (jackpot)
    );

    always #83 clk = ~clk;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Digits packed as {digit2, digit1, digit0}; flags as {win, pair, jackpot}.
    function automatic logic [11:0] digs();
        return {digit2, digit1, digit0};
    endfunction

    function automatic logic [11:0] flags();
        return {9'd0, win, pair, jackpot};
    endfunction

    task automatic ticks(input int n);
        repeat (n) begin
            @(negedge clk) tick10Hz = 1'b1;
            @(negedge clk) tick10Hz = 1'b0;
        end
    endtask

    task automatic press_start();
        @(negedge clk) startBtn = 1'b1;
        repeat (3) @(negedge clk);
        startBtn = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Stop event lands in the cycle where tick10Hz is optionally raised.
    task automatic press_stop(input logic [2:0] mask, input logic with_tick);
        @(negedge clk) stopBtn = mask;
        @(negedge clk);
        @(negedge clk) tick10Hz = with_tick;
        @(negedge clk) tick10Hz = 1'b0;
        stopBtn = 3'b000;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk) resetN = 1'b0;
        @(negedge clk) resetN = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        resetN   = 1'b0;
        tick10Hz = 1'b0;
        startBtn = 1'b0;
        stopBtn  = 3'b000;
        repeat (2) @(negedge clk);
        chk("rst_digits", digs(), 12'h000);
        chk("rst_stopped", {9'd0, stopped}, 12'h000);
        chk("rst_busy_flags", {8'd0, busy, win, pair, jackpot}, 12'h000);
        resetN = 1'b1;
        repeat (4) @(negedge clk);

        // Five ticks then simultaneous stop: 5,5,5 win.
        ticks(2);
        chk("idle_tick_ignored", digs(), 12'h000);
        press_stop(3'b111, 1'b0);
        chk("idle_stop_ignored", {9'd0, stopped}, 12'h000);
        press_start();
        chk("spin_busy", {11'd0, busy}, 12'h001);
        ticks(5);
        chk("five_ticks", digs(), 12'h555);
        chk("flags_in_spin", flags(), 12'h000);
        press_stop(3'b111, 1'b0);
        chk("555_stopped", {9'd0, stopped}, 12'h007);
        chk("555_busy", {11'd0, busy}, 12'h000);
        chk("555_flags", flags(), 12'h004);

        // Restart from RESULT keeps digits as the start point.
        press_start();
        chk("restart_flags", flags(), 12'h000);
        chk("restart_stopped", {9'd0, stopped}, 12'h000);
        ticks(1);
        chk("restart_digits", digs(), 12'h286);

        // Nine ticks: 9,7,3 no win; ticks in RESULT ignored.
        do_reset();
        chk("reset_digits", digs(), 12'h000);
        press_start();
        ticks(9);
        press_stop(3'b111, 1'b0);
        chk("973_digits", digs(), 12'h379);
        chk("973_flags", flags(), 12'h000);
        ticks(1);
        chk("result_tick_ignored", digs(), 12'h379);
        chk("result_busy", {11'd0, busy}, 12'h000);

        // Staggered stops ending in a pair; repeated stop and start ignored.
        do_reset();
        press_start();
        ticks(1);
        press_stop(3'b001, 1'b0);
        chk("reel0_frozen", {9'd0, stopped}, 12'h001);
        chk("reel0_digits", digs(), 12'h731);
        press_start();
        chk("start_in_spin_ignored", {8'd0, busy, stopped}, 12'h009);
        ticks(6);
        press_stop(3'b010, 1'b0);
        ticks(1);
        press_stop(3'b001, 1'b0);
        chk("repeat_stop_ignored", {9'd0, stopped}, 12'h003);
        press_stop(3'b100, 1'b0);
        chk("pair_digits", digs(), 12'h611);
        chk("pair_flags", flags(), 12'h002);

        // Jackpot 7,7,7.
        do_reset();
        press_start();
        ticks(1);
        press_stop(3'b100, 1'b0);
        ticks(6);
        press_stop(3'b001, 1'b0);
        ticks(2);
        press_stop(3'b010, 1'b0);
        chk("jackpot_digits", digs(), 12'h777);
        chk("jackpot_flags", flags(), 12'h005);

        // Timeout after 100 ticks freezes at 0,0,0.
        do_reset();
        press_start();
        ticks(99);
        chk("tick99_digits", digs(), 12'h379);
        chk("tick99_running", {8'd0, busy, stopped}, 12'h008);
        ticks(1);
        repeat (3) @(negedge clk);
        chk("timeout_stopped", {8'd0, busy, stopped}, 12'h007);
        chk("timeout_digits", digs(), 12'h000);
        chk("timeout_flags", flags(), 12'h004);

        // Stop coinciding with a tick holds the pre-tick value.
        do_reset();
        press_start();
        ticks(2);
        press_stop(3'b001, 1'b1);
        chk("stop_with_tick", digs(), 12'h192);
        chk("stop_with_tick_stopped", {9'd0, stopped}, 12'h001);

        // Stop reel0 early, 11 more ticks, stop the rest: 1,6,4 no pair.
        do_reset();
        press_start();
        ticks(1);
        press_stop(3'b001, 1'b0);
        ticks(11);
        press_stop(3'b110, 1'b0);
        chk("164_digits", digs(), 12'h461);
        chk("164_flags", flags(), 12'h000);

        // Re-run, then asynchronous reset mid-spin with buttons held.
        press_start();
        ticks(3);
        chk("rerun_digits", digs(), 12'h554);
        @(negedge clk) startBtn = 1'b1;
        stopBtn = 3'b111;
        @(posedge clk);
        #20 resetN = 1'b0;
        #1;
        chk("async_rst_digits", digs(), 12'h000);
        chk("async_rst_outs", {5'd0, stopped, busy, win, pair, jackpot}, 12'h000);
        @(negedge clk) resetN = 1'b1;
        repeat (10) @(negedge clk);
        chk("held_btn_no_event", {8'd0, busy, stopped}, 12'h000);
        startBtn = 1'b0;
        stopBtn  = 3'b000;
        repeat (3) @(negedge clk);
        press_start();
        chk("press_after_release", {11'd0, busy}, 12'h001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/slot_reel_ctrl.md
SLOT_REEL_CTRL -- requirements
Module: slot_reel_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_TICKS, default 100: tick10Hz pulses with no stop event before all running reels auto-stop.
REQ-002 SHALL have port clock6MHz, input, 1: the single system clock (6 MHz); all state on its rising edge.
REQ-003 SHALL have port resetN, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port tick10Hz, input, 1: one-cycle enable pulse at 10 Hz, clock6MHz domain, from the clock-division stage.
REQ-005 SHALL have port startBtn, input, 1: raw asynchronous start push-button level, active-high.
REQ-006 SHALL have port stopBtn, input, 3: raw asynchronous per-reel stop button levels, active-high, bit i = reel i.
REQ-007 SHALL have ports digit0, digit1, digit2, output, 4 each: current BCD symbol of reel 0/1/2, consumed by the dynamic display stage.
REQ-008 SHALL have port stopped, output, 3: bit i high while reel i is frozen.
REQ-009 SHALL have port busy, output, 1: high in SPIN.
REQ-010 SHALL have ports win, pair, jackpot, output, 1 each: result flags, valid in RESULT only.

Function
REQ-011 SHALL synchronise startBtn and each stopBtn bit through two flops, then rising-edge detect; only detected edges (one-cycle events) act.
REQ-012 SHALL implement FSM states IDLE, SPIN, RESULT.
REQ-013 IDLE: start event -> SPIN; stopped cleared to 3'b000; timeout counter cleared.
REQ-014 SPIN: on tick10Hz each running reel advances modulo 10: reel0 +1, reel1 +3, reel2 +7 (e.g. reel2 8 -> 5); frozen reels hold.
REQ-015 SPIN: stop event on bit i freezes reel i in that cycle; stop on an already-frozen reel is ignored.
REQ-016 Stop event and tick10Hz in the same cycle: reel holds its pre-tick value.
REQ-017 Simultaneous stop events on several bits SHALL freeze all of them in the same cycle.
REQ-018 Timeout counter SHALL clear on SPIN entry and on any accepted stop event, increment on tick10Hz, and when it reaches TIMEOUT_TICKS all running reels freeze in that cycle (tick on that cycle not applied).
REQ-019 SHALL transition SPIN -> RESULT in the cycle after stopped becomes 3'b111.
REQ-020 RESULT flags, registered on RESULT entry, held through RESULT: win = all three digits equal; jackpot = win and digits = 7; pair = exactly two digits equal; flags mutually consistent (pair never with win).
REQ-021 RESULT: start event -> SPIN (flags cleared, stopped cleared, digits retained as spin start point).
REQ-022 Start events in SPIN and stop events in IDLE/RESULT SHALL be ignored.
REQ-023 tick10Hz SHALL be ignored outside SPIN.
REQ-024 busy = 1 exactly in SPIN; win/pair/jackpot = 0 outside RESULT.

Reset
REQ-025 resetN low SHALL immediately force IDLE, digits 0, stopped 3'b000, busy/win/pair/jackpot 0, synchroniser and edge-detect flops 0, timeout counter 0, including mid-spin.
REQ-026 A button held high across reset release SHALL NOT generate an event until released and pressed again.

Structure
REQ-027 State encoding and reel step constants (1, 3, 7) SHALL reside in shared package slot_pkg.
REQ-028 Reel digit storage and modulo-10 stepping SHALL be a sub-module reel_counter (inputs step, advance, freeze; output 4-bit digit), instantiated three times.

Verification
REQ-029 Reset, start, 5 ticks, stop all three simultaneously -> digits 5,5,5; RESULT next cycle; win=1, pair=0, jackpot=0.
REQ-030 Start, 9 ticks, stop all -> digits 9,7,3; win=pair=jackpot=0; 1 more tick in RESULT -> digits unchanged.
REQ-031 Start, stop reel0 at tick 1 (digit 1), reel1 at tick 7 (digit 1), reel2 at tick 8 (digit 6) -> pair=1, win=0; stop repeated on reel0 ignored.
REQ-032 Start, no stops for TIMEOUT_TICKS=100 ticks -> all reels freeze at 0,0,0 (100 mod 10), RESULT, win=1, jackpot=0; stop in same cycle as tick -> pre-tick value held.
REQ-033 Start, 1 tick, stop reel0; 11 more ticks (reel1/2 reach 6/4), stop reel1 and reel2 -> pair=0; resetN pulse mid-spin on re-run -> all outputs 0, IDLE, held button produces no event.
